// File: rtl/cache_line_xfer_ctrl_pkg.sv
// Shared types and defaults for the cache-line transfer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_xfer_pkg;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_WORD_W         = 32;
  localparam int DEF_ADDR_W         = 32;

  // Transfer sequencer states: optional write-back, then fill, then a done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } xfer_state_t;

  // Number of byte-offset bits covered by one cache line.
  function automatic int line_ofs_w(input int words, input int word_w);
    return $clog2((words * word_w) / 8);
  endfunction

endpackage

// File: rtl/cache_line_xfer_ctrl_line_word_buf.sv
// Line-wide register written one word at a time; used to assemble the fetched line.
// Latency: a written word is visible on line the cycle after wr_en.
// Backpressure: none; one word write per cycle, caller decides when.
module line_word_buf #(
  parameter  int WORDS  = 8,
  parameter  int WORD_W = 32,
  localparam int LINE_W = WORDS * WORD_W,
  localparam int IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] line_q;

  // Word-indexed write; a reset wipes any partially assembled line.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else if (wr_en) begin
      line_q[idx*WORD_W +: WORD_W] <= wdata;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/cache_line_xfer_ctrl.sv
// Cache-line transfer sequencer: optional dirty write-back of 8 words, then 8-word fill.
// Latency: clean miss done 9 cycles after request, dirty 17 (zero-wait memory).
// Backpressure: each beat holds req/addr/data until mem_ack; xfer_req ignored while busy.
module cache_line_xfer_ctrl
  import cache_xfer_pkg::*;
#(
  parameter  int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter  int WORD_W         = DEF_WORD_W,
  parameter  int ADDR_W         = DEF_ADDR_W,
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xfer_req,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [LINE_W-1:0] wb_line,
  output logic              busy,
  output logic              done,
  output logic [LINE_W-1:0] fill_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int OFS_W   = line_ofs_w(WORDS_PER_LINE, WORD_W);
  localparam int BEAT_W  = $clog2(WORDS_PER_LINE);
  localparam int BYTE_SH = OFS_W - BEAT_W;
  localparam int BASE_W  = ADDR_W - OFS_W;

  typedef logic [BEAT_W-1:0] beat_t;
  localparam beat_t LAST_BEAT = beat_t'(WORDS_PER_LINE - 1);

  xfer_state_t       state_q, state_d;
  beat_t             beat_q, beat_d;
  // Only the line-aligned upper address bits are kept, so the per-beat
  // offset is concatenated below them and can never carry upward.
  logic [BASE_W-1:0] wb_base_q, wb_base_d;
  logic [BASE_W-1:0] fill_base_q, fill_base_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;

  logic [OFS_W-1:0]  beat_ofs;
  logic              fill_wr_en;
  logic              unused_addr_lsbs;

  assign beat_ofs   = OFS_W'(beat_q) << BYTE_SH;
  assign fill_wr_en = (state_q == FILL) && mem_ack;

  // The in-line byte offset of each request is discarded by design.
  assign unused_addr_lsbs = ^{wb_addr[OFS_W-1:0], fill_addr[OFS_W-1:0]};

  // Next-state, beat counter and request latching.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    wb_line_d   = wb_line_q;
    case (state_q)
      IDLE: begin
        if (xfer_req) begin
          wb_base_d   = wb_addr[ADDR_W-1:OFS_W];
          fill_base_d = fill_addr[ADDR_W-1:OFS_W];
          wb_line_d   = wb_line;
          beat_d      = '0;
          state_d     = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        if (mem_ack) begin
          // Natural wrap of the counter returns beat to 0 for the fill phase.
          beat_d = beat_q + beat_t'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          beat_d = beat_q + beat_t'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Acks and requests seen here are deliberately dropped.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wb_base_q   <= '0;
      fill_base_q <= '0;
      wb_line_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
      wb_line_q   <= wb_line_d;
    end
  end

  // Memory-side outputs decoded from registered state only, so they stay
  // stable for the whole beat regardless of when mem_ack arrives.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_base_q, beat_ofs};
        mem_wdata = wb_line_q[beat_q*WORD_W +: WORD_W];
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {fill_base_q, beat_ofs};
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  line_word_buf #(
    .WORDS  (WORDS_PER_LINE),
    .WORD_W (WORD_W)
  ) u_fill_buf (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fill_wr_en),
    .idx   (beat_q),
    .wdata (mem_rdata),
    .line  (fill_line)
  );

endmodule

// File: tb/tb_cache_line_xfer_ctrl.sv
// Self-checking bench for cache_line_xfer_ctrl with a queue-based beat model.
// Latency: checks done timing for zero-wait memory and random ack delays.
// Backpressure: exercises held requests, ignored xfer_req and spurious acks.
module tb_cache_line_xfer_ctrl;

  localparam int WPL = 8;
  localparam int WW  = 32;
  localparam int AW  = 32;
  localparam int LW  = WPL * WW;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          xfer_req = 1'b0;
  logic          victim_dirty = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [AW-1:0] fill_addr = '0;
  logic [LW-1:0] wb_line = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] fill_line;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  always #5 clk = ~clk;

  cache_line_xfer_ctrl #(
    .WORDS_PER_LINE (WPL),
    .WORD_W         (WW),
    .ADDR_W         (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .xfer_req     (xfer_req),
    .victim_dirty (victim_dirty),
    .wb_addr      (wb_addr),
    .fill_addr    (fill_addr),
    .wb_line      (wb_line),
    .busy         (busy),
    .done         (done),
    .fill_line    (fill_line),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  int checks = 0;
  int errors = 0;

  // Observed beats (accepted by an ack) and read data handed to the DUT.
  bit          q_we[$];
  logic [31:0] q_addr[$];
  logic [31:0] q_wdata[$];
  logic [31:0] rd_sent[$];
  int          n_done;
  int          n_stab;
  int          done_edge;
  bit          tmo;

  // Expected beat sequence from the model.
  bit          e_we[$];
  logic [31:0] e_addr[$];
  logic [31:0] e_data[$];

  logic [LW-1:0] last_fill_exp = '0;

  // Model: optional 8 writes of the victim line word 0 first, then 8 reads.
  function automatic void build_exp(input bit dirty, input logic [31:0] wa,
                                    input logic [31:0] fa, input logic [LW-1:0] wl);
    e_we.delete();
    e_addr.delete();
    e_data.delete();
    if (dirty) begin
      for (int i = 0; i < WPL; i++) begin
        e_we.push_back(1'b1);
        e_addr.push_back((wa & LINE_MASK) + 32'(4 * i));
        e_data.push_back(wl[i*WW +: WW]);
      end
    end
    for (int i = 0; i < WPL; i++) begin
      e_we.push_back(1'b0);
      e_addr.push_back((fa & LINE_MASK) + 32'(4 * i));
      e_data.push_back(32'h0);
    end
  endfunction

  // Model: the filled line is the read data in beat order.
  function automatic logic [LW-1:0] line_from_rd();
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < rd_sent.size() && i < WPL; i++) l[i*WW +: WW] = rd_sent[i];
    return l;
  endfunction

  // Memory responder and observer for one transfer; records beats, done pulses
  // and stability violations; stops when busy falls or the edge budget runs out.
  task automatic run_xfer(input bit skip_req, input bit dirty, input logic [31:0] wa,
                          input logic [31:0] fa, input logic [LW-1:0] wl,
                          input int maxdly, input int inject_beat, input bit seq_rdata,
                          input bit ack_in_done, input bit req_at_done,
                          input logic [31:0] next_fa);
    int edges;
    int dly;
    int fbeats;
    bit hold;
    bit h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    q_we.delete();
    q_addr.delete();
    q_wdata.delete();
    rd_sent.delete();
    n_done = 0;
    n_stab = 0;
    done_edge = -1;
    tmo = 1'b1;
    if (!skip_req) begin
      xfer_req = 1'b1;
      victim_dirty = dirty;
      wb_addr = wa;
      fill_addr = fa;
      wb_line = wl;
      @(posedge clk);
      @(negedge clk);
    end
    // Scramble request inputs: only latched values may be used from now on.
    xfer_req = 1'b0;
    victim_dirty = 1'($urandom);
    wb_addr = $urandom;
    fill_addr = $urandom;
    for (int i = 0; i < WPL; i++) wb_line[i*WW +: WW] = $urandom;
    edges = 0;
    hold = 1'b0;
    fbeats = 0;
    h_we = 1'b0;
    h_addr = '0;
    h_wdata = '0;
    dly = $urandom_range(0, maxdly);
    while (edges < 200) begin
      if (hold) begin
        if (mem_req !== 1'b1 || mem_addr !== h_addr || mem_we !== h_we ||
            (h_we && mem_wdata !== h_wdata)) n_stab++;
      end
      if (done === 1'b1) begin
        n_done++;
        done_edge = edges;
      end
      if (busy === 1'b0) begin
        tmo = 1'b0;
        break;
      end
      mem_ack = 1'b0;
      hold = 1'b0;
      xfer_req = 1'b0;
      mem_rdata = seq_rdata ? 32'(32'hA0 + fbeats) : $urandom;
      if (mem_req === 1'b1) begin
        if (!mem_we && fbeats == inject_beat) begin
          xfer_req = 1'b1;
          victim_dirty = 1'b1;
          fill_addr = fa ^ 32'h0001_0000;
        end
        if (dly > 0) begin
          dly--;
          hold = 1'b1;
          h_addr = mem_addr;
          h_we = mem_we;
          h_wdata = mem_wdata;
        end else begin
          mem_ack = 1'b1;
          q_we.push_back(mem_we);
          q_addr.push_back(mem_addr);
          q_wdata.push_back(mem_wdata);
          if (!mem_we) begin
            rd_sent.push_back(mem_rdata);
            fbeats++;
          end
          dly = $urandom_range(0, maxdly);
        end
      end else if (done === 1'b1) begin
        if (ack_in_done) mem_ack = 1'b1;
        if (req_at_done) begin
          xfer_req = 1'b1;
          victim_dirty = 1'b0;
          fill_addr = next_fa;
        end
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_ctl got req=%b we=%b want 0 0", mem_req, mem_we);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (fill_line !== '0) begin
      errors++;
      $display("FAIL reset_fill_line got %h want 0", fill_line);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_miss();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = $urandom;
    for (int i = 0; i < WPL; i++) exp_line[i*WW +: WW] = 32'(32'hA0 + i);
    build_exp(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, wl);
    run_xfer(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, wl, 0, -1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (tmo) begin errors++; $display("FAIL clean_timeout got busy=%b want 0", busy); end
    checks++;
    if (q_addr.size() != e_addr.size()) begin
      errors++;
      $display("FAIL clean_beat_count got %0d want %0d", q_addr.size(), e_addr.size());
    end else begin
      for (int i = 0; i < e_addr.size(); i++) begin
        checks++;
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i]) begin
          errors++;
          $display("FAIL clean_beat%0d got we=%b addr=%h want we=%b addr=%h",
                   i, q_we[i], q_addr[i], e_we[i], e_addr[i]);
        end
      end
    end
    checks++;
    if (n_done != 1 || done_edge != 8) begin
      errors++;
      $display("FAIL clean_done got pulses=%0d edge=%0d want 1 8", n_done, done_edge);
    end
    checks++;
    if (fill_line !== exp_line) begin
      errors++;
      $display("FAIL clean_fill_line got %h want %h", fill_line, exp_line);
    end
    last_fill_exp = exp_line;
  endtask

  task automatic test_dirty_miss();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = 32'(32'h100 + i);
    build_exp(1'b1, 32'h0000_8000, 32'h0000_4000, wl);
    run_xfer(1'b0, 1'b1, 32'h0000_8000, 32'h0000_4000, wl, 0, -1, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_line = line_from_rd();
    checks++;
    if (tmo) begin errors++; $display("FAIL dirty_timeout got busy=%b want 0", busy); end
    checks++;
    if (q_addr.size() != e_addr.size()) begin
      errors++;
      $display("FAIL dirty_beat_count got %0d want %0d", q_addr.size(), e_addr.size());
    end else begin
      for (int i = 0; i < e_addr.size(); i++) begin
        checks++;
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i] ||
            (e_we[i] && q_wdata[i] !== e_data[i])) begin
          errors++;
          $display("FAIL dirty_beat%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                   i, q_we[i], q_addr[i], q_wdata[i], e_we[i], e_addr[i], e_data[i]);
        end
      end
    end
    checks++;
    if (n_done != 1 || done_edge != 16) begin
      errors++;
      $display("FAIL dirty_done got pulses=%0d edge=%0d want 1 16", n_done, done_edge);
    end
    checks++;
    if (fill_line !== exp_line) begin
      errors++;
      $display("FAIL dirty_fill_line got %h want %h", fill_line, exp_line);
    end
    last_fill_exp = exp_line;
  endtask

  task automatic test_random_delays();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    logic [31:0] wa;
    logic [31:0] fa;
    bit dirty;
    int bad;
    for (int t = 0; t < 8; t++) begin
      dirty = 1'($urandom);
      wa = $urandom;
      fa = $urandom;
      for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = $urandom;
      build_exp(dirty, wa, fa, wl);
      run_xfer(1'b0, dirty, wa, fa, wl, 3, -1, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_line = line_from_rd();
      checks++;
      if (tmo || n_done != 1) begin
        errors++;
        $display("FAIL rand%0d_done got timeout=%b pulses=%0d want 0 1", t, tmo, n_done);
      end
      checks++;
      if (n_stab != 0) begin
        errors++;
        $display("FAIL rand%0d_stability got %0d unstable cycles want 0", t, n_stab);
      end
      checks++;
      bad = 0;
      if (q_addr.size() != e_addr.size()) bad = 1;
      else
        for (int i = 0; i < e_addr.size(); i++)
          if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i] ||
              (e_we[i] && q_wdata[i] !== e_data[i])) bad++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand%0d_beats got %0d beats %0d wrong want %0d beats 0 wrong",
                 t, q_addr.size(), bad, e_addr.size());
      end
      checks++;
      if (fill_line !== exp_line) begin
        errors++;
        $display("FAIL rand%0d_fill_line got %h want %h", t, fill_line, exp_line);
      end
      last_fill_exp = exp_line;
    end
  endtask

  task automatic test_req_while_busy();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    int bad;
    for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = $urandom;
    build_exp(1'b0, 32'h0, 32'h2000_0040, wl);
    run_xfer(1'b0, 1'b0, 32'h0, 32'h2000_0040, wl, 1, 3, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_line = line_from_rd();
    checks++;
    bad = 0;
    if (q_addr.size() != e_addr.size()) bad = 1;
    else
      for (int i = 0; i < e_addr.size(); i++)
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i]) bad++;
    if (bad != 0 || tmo) begin
      errors++;
      $display("FAIL busyreq_beats got %0d beats %0d wrong timeout=%b want %0d 0 0",
               q_addr.size(), bad, tmo, e_addr.size());
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL busyreq_done_count got %0d want 1", n_done);
    end
    checks++;
    if (fill_line !== exp_line) begin
      errors++;
      $display("FAIL busyreq_fill_line got %h want %h", fill_line, exp_line);
    end
    last_fill_exp = exp_line;
    // Nothing may have been queued by the ignored request.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL busyreq_no_queue cyc%0d got busy=%b req=%b want 0 0", c, busy, mem_req);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    logic [31:0] nfa;
    int bad;
    nfa = 32'h0BAD_F00D;
    for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = $urandom;
    run_xfer(1'b0, 1'b1, 32'h0000_3000, 32'h0000_5000, wl, 0, -1, 1'b0, 1'b0, 1'b1, nfa);
    // Request raised in the DONE cycle must not be taken there: IDLE for one cycle.
    checks++;
    if (tmo || n_done != 1) begin
      errors++;
      $display("FAIL b2b_first got timeout=%b pulses=%0d want 0 1", tmo, n_done);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_addr !== (nfa & LINE_MASK) || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b addr=%h we=%b want 1 %h 0",
               busy, mem_addr, mem_we, nfa & LINE_MASK);
    end
    build_exp(1'b0, 32'h0, nfa, wl);
    run_xfer(1'b1, 1'b0, 32'h0, nfa, wl, 1, -1, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_line = line_from_rd();
    checks++;
    bad = 0;
    if (q_addr.size() != e_addr.size()) bad = 1;
    else
      for (int i = 0; i < e_addr.size(); i++)
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i]) bad++;
    if (bad != 0 || tmo || n_done != 1) begin
      errors++;
      $display("FAIL b2b_second got beats=%0d wrong=%0d timeout=%b pulses=%0d want 8 0 0 1",
               q_addr.size(), bad, tmo, n_done);
    end
    checks++;
    if (fill_line !== exp_line) begin
      errors++;
      $display("FAIL b2b_fill_line got %h want %h", fill_line, exp_line);
    end
    last_fill_exp = exp_line;
  endtask

  task automatic test_spurious_ack();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    int bad;
    for (int c = 0; c < 3; c++) begin
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || fill_line !== last_fill_exp) begin
        errors++;
        $display("FAIL spur_idle cyc%0d got busy=%b req=%b line=%h want 0 0 %h",
                 c, busy, mem_req, fill_line, last_fill_exp);
      end
    end
    mem_ack = 1'b0;
    for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = $urandom;
    build_exp(1'b1, 32'h7700_0010, 32'h6600_0020, wl);
    run_xfer(1'b0, 1'b1, 32'h7700_0010, 32'h6600_0020, wl, 2, -1, 1'b0, 1'b1, 1'b0, 32'h0);
    exp_line = line_from_rd();
    checks++;
    bad = 0;
    if (q_addr.size() != e_addr.size()) bad = 1;
    else
      for (int i = 0; i < e_addr.size(); i++)
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i] ||
            (e_we[i] && q_wdata[i] !== e_data[i])) bad++;
    if (bad != 0 || tmo || n_done != 1) begin
      errors++;
      $display("FAIL spur_after_idle got beats=%0d wrong=%0d timeout=%b pulses=%0d want 16 0 0 1",
               q_addr.size(), bad, tmo, n_done);
    end
    checks++;
    if (fill_line !== exp_line) begin
      errors++;
      $display("FAIL spur_done_fill_line got %h want %h", fill_line, exp_line);
    end
    last_fill_exp = exp_line;
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] wl;
    logic [LW-1:0] exp_line;
    logic [31:0] wa;
    int bad;
    wa = 32'h1357_9BDF;
    for (int i = 0; i < WPL; i++) wl[i*WW +: WW] = $urandom;
    xfer_req = 1'b1;
    victim_dirty = 1'b1;
    wb_addr = wa;
    fill_addr = $urandom;
    wb_line = wl;
    @(posedge clk);
    @(negedge clk);
    xfer_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== (wa & LINE_MASK) + 32'd16 ||
        mem_wdata !== wl[4*WW +: WW]) begin
      errors++;
      $display("FAIL rstmid_beat4 got req=%b we=%b addr=%h data=%h want 1 1 %h %h",
               mem_req, mem_we, mem_addr, mem_wdata, (wa & LINE_MASK) + 32'd16, wl[4*WW +: WW]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || fill_line !== '0) begin
      errors++;
      $display("FAIL rstmid_abort got busy=%b req=%b line=%h want 0 0 0", busy, mem_req, fill_line);
    end
    rst = 1'b0;
    build_exp(1'b0, 32'h0, 32'h00C0_FFEE, wl);
    run_xfer(1'b0, 1'b0, 32'h0, 32'h00C0_FFEE, wl, 0, -1, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_line = line_from_rd();
    checks++;
    bad = 0;
    if (q_addr.size() != e_addr.size()) bad = 1;
    else
      for (int i = 0; i < e_addr.size(); i++)
        if (q_addr[i] !== e_addr[i] || q_we[i] !== e_we[i]) bad++;
    if (bad != 0 || tmo || n_done != 1 || done_edge != 8) begin
      errors++;
      $display("FAIL rstmid_fresh got beats=%0d wrong=%0d timeout=%b pulses=%0d edge=%0d want 8 0 0 1 8",
               q_addr.size(), bad, tmo, n_done, done_edge);
    end
    checks++;
    if (fill_line !== exp_line) begin
      errors++;
      $display("FAIL rstmid_fill_line got %h want %h", fill_line, exp_line);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_random_delays();
    test_req_while_busy();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
